// File: rtl/sccb_cfg_pkg.sv
// rtl/sccb_cfg_pkg.sv - shared types, constants and divider math for the SCCB register sequencer
package sccb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int SLOTS_PER_BYTE  = 9;
  localparam int BYTES_PER_WRITE = 4;
  localparam int QUARTERS        = 4;

  // Cycles per quarter of an SCL period.
  function automatic int calc_div(input int clk_hz, input int scl_hz);
    return clk_hz / (QUARTERS * scl_hz);
  endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// rtl/sccb_quarter_tick.sv - free-running quarter-period tick generator for SCCB slot timing
module sccb_quarter_tick #(
  parameter int DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count DIV cycles per quarter; clear realigns Q0 to the start of a write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt     <= '0;
      quarter <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/sccb_reg_config.sv
// rtl/sccb_reg_config.sv - walks a register table and issues one 3-phase SCCB write per entry
module sccb_reg_config
  import sccb_cfg_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         SCCB_FREQ_HZ = 250_000,
  parameter int         REG_NUM      = 256,
  parameter logic [7:0] DEV_ADDR     = 8'h78
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        initial_en,
  output logic [9:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        sccb_scl,
  output logic        sccb_sda_o,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_i,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_nack
);

  localparam int         DIV       = calc_div(CLK_FREQ_HZ, SCCB_FREQ_HZ);
  localparam logic [9:0] LAST_ADDR = 10'(REG_NUM - 1);
  localparam logic [3:0] ACK_IDX   = 4'(SLOTS_PER_BYTE - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WRITE - 1);
  localparam logic [1:0] LAST_Q    = 2'(QUARTERS - 1);

  state_t      state;
  state_t      state_nx;
  logic        tick;
  logic [1:0]  quarter;
  logic [3:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_word;
  logic        slot_end;
  logic        ack_slot;
  logic        write_end;
  logic        abort;
  logic        tick_clear;

  assign slot_end   = tick && (quarter == LAST_Q);
  assign ack_slot   = (bit_cnt == ACK_IDX);
  assign write_end  = ack_slot && (byte_cnt == LAST_BYTE);
  assign abort      = !initial_en && (state != ST_IDLE);
  // Quarter counter restarts on the edge that enters START.
  assign tick_clear = (state == ST_WAIT);
  assign sccb_sda_o = 1'b0;

  sccb_quarter_tick #(
    .DIV(DIV)
  ) u_quarter_tick (
    .clk    (clk_50M),
    .reset  (reset),
    .clear  (tick_clear),
    .tick   (tick),
    .quarter(quarter)
  );

  // State register; reset overrides everything.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus bus and status outputs decoded from state and quarter.
  always_comb begin
    state_nx    = state;
    sccb_scl    = 1'b1;
    sccb_sda_oe = 1'b0;
    cfg_busy    = 1'b0;
    cfg_done    = 1'b0;

    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (initial_en) state_nx = ST_FETCH;
        ST_FETCH: state_nx = ST_WAIT;
        ST_WAIT:  state_nx = ST_START;
        ST_START: if (slot_end) state_nx = ST_BYTE;
        ST_BYTE:  if (slot_end && write_end) state_nx = ST_STOP;
        ST_STOP:  if (slot_end) state_nx = ST_GAP;
        ST_GAP: begin
          if (slot_end) state_nx = (rom_addr == LAST_ADDR) ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_IDLE;
      endcase
    end

    case (state)
      ST_FETCH, ST_WAIT, ST_GAP: begin
        cfg_busy = 1'b1;
      end
      ST_START: begin
        cfg_busy    = 1'b1;
        sccb_sda_oe = quarter[1];
      end
      ST_BYTE: begin
        cfg_busy    = 1'b1;
        sccb_scl    = quarter[1];
        sccb_sda_oe = !ack_slot && !shift_word[31];
      end
      ST_STOP: begin
        cfg_busy    = 1'b1;
        sccb_scl    = (quarter != 2'd0);
        sccb_sda_oe = !quarter[1];
      end
      ST_DONE: begin
        cfg_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Table index, slot counters, shift word and sticky NACK flag.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rom_addr   <= 10'd0;
      bit_cnt    <= 4'd0;
      byte_cnt   <= 2'd0;
      shift_word <= 32'd0;
      cfg_nack   <= 1'b0;
    end else if (abort) begin
      rom_addr <= 10'd0;
      bit_cnt  <= 4'd0;
      byte_cnt <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (initial_en) begin
            rom_addr <= 10'd0;
            cfg_nack <= 1'b0;
          end
        end
        ST_WAIT: begin
          shift_word <= {DEV_ADDR, rom_data};
          bit_cnt    <= 4'd0;
          byte_cnt   <= 2'd0;
        end
        ST_BYTE: begin
          // ACK sampled on the edge that opens Q3; NACK is recorded but never stops the walk.
          if (ack_slot && tick && (quarter == 2'd2) && sccb_sda_i) begin
            cfg_nack <= 1'b1;
          end
          if (slot_end) begin
            if (ack_slot) begin
              bit_cnt  <= 4'd0;
              byte_cnt <= byte_cnt + 2'd1;
            end else begin
              bit_cnt    <= bit_cnt + 4'd1;
              shift_word <= {shift_word[30:0], 1'b0};
            end
          end
        end
        ST_GAP: begin
          if (slot_end && (rom_addr != LAST_ADDR)) begin
            rom_addr <= rom_addr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_reg_config.sv
// tb/tb_sccb_reg_config.sv - directed self-checking bench for sccb_reg_config
module tb_sccb_reg_config;

  logic        clk_50M = 1'b0;
  logic        reset;
  logic        initial_en;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic        sccb_scl;
  logic        sccb_sda_o;
  logic        sccb_sda_oe;
  logic        sccb_sda_i;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_nack;

  int n_cmp = 0;
  int n_err = 0;
  int t_rel = 0;

  sccb_reg_config #(
    .CLK_FREQ_HZ (50_000_000),
    .SCCB_FREQ_HZ(250_000),
    .REG_NUM     (2),
    .DEV_ADDR    (8'h78)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .initial_en (initial_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_scl   (sccb_scl),
    .sccb_sda_o (sccb_sda_o),
    .sccb_sda_oe(sccb_sda_oe),
    .sccb_sda_i (sccb_sda_i),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_nack   (cfg_nack)
  );

  always #10 clk_50M = ~clk_50M;

  // Two-entry register table with one cycle of read latency.
  always @(posedge clk_50M) rom_data <= rom_addr[0] ? 24'h310303 : 24'h300882;

  // Bus monitor: decodes START/STOP framed writes and checks SCL timing.
  logic        prev_scl = 1'b1;
  logic        prev_oe = 1'b0;
  logic        in_frame = 1'b0;
  int          cyc = 0;
  int          nbits = 0;
  int          last_rise = 0;
  int          proto_err = 0;
  int          period_err = 0;
  int          high_err = 0;
  int          scl_edges = 0;
  logic [31:0] word = 32'd0;
  logic [31:0] frames[$];

  always @(negedge clk_50M) begin
    cyc++;
    if (sccb_scl != prev_scl) scl_edges++;
    if (prev_scl && sccb_scl && !prev_oe && sccb_sda_oe) begin
      if (in_frame) proto_err++;
      in_frame = 1'b1;
      nbits = 0;
      word = 32'd0;
    end else if (prev_scl && sccb_scl && prev_oe && !sccb_sda_oe) begin
      if (!in_frame || nbits != 37) proto_err++;
      else frames.push_back(word);
      in_frame = 1'b0;
    end
    if (!prev_scl && sccb_scl && in_frame) begin
      nbits++;
      if (nbits >= 2 && nbits <= 36 && (cyc - last_rise) != 200) period_err++;
      last_rise = cyc;
      if (nbits <= 36 && (nbits % 9) != 0) word = {word[30:0], ~sccb_sda_oe};
    end
    if (prev_scl && !sccb_scl && in_frame && nbits >= 1 && nbits <= 36 && (cyc - last_rise) != 100) high_err++;
    prev_scl = sccb_scl;
    prev_oe = sccb_sda_oe;
  end

  task automatic mon_clear();
    in_frame = 1'b0;
    nbits = 0;
    proto_err = 0;
    period_err = 0;
    high_err = 0;
    scl_edges = 0;
    frames.delete();
  endtask

  task automatic start_walk();
    initial_en = 1'b1;
    @(posedge clk_50M);
    #1;
    t_rel = 0;
  endtask

  task automatic step_to(input int n);
    repeat (n - t_rel) @(posedge clk_50M);
    #1;
    t_rel = n;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    initial_en = 1'b0;
    sccb_sda_i = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    n_cmp++; if (sccb_scl !== 1'b1) begin n_err++; $display("FAIL rst_scl: got %b expected 1", sccb_scl); end
    n_cmp++; if (sccb_sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b expected 0", sccb_sda_oe); end
    n_cmp++; if (sccb_sda_o !== 1'b0) begin n_err++; $display("FAIL rst_sda_o: got %b expected 0", sccb_sda_o); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", rom_addr); end
    n_cmp++; if ({cfg_busy, cfg_done, cfg_nack} !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b expected 000", {cfg_busy, cfg_done, cfg_nack}); end
    reset = 1'b0;
    mon_clear();
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_50M);
      if (sccb_scl !== 1'b1 || sccb_sda_oe !== 1'b0 || sccb_sda_o !== 1'b0 || rom_addr !== 10'd0 ||
          cfg_busy !== 1'b0 || cfg_done !== 1'b0 || cfg_nack !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (scl_edges !== 0) begin n_err++; $display("FAIL idle_scl_toggle: got %0d edges expected 0", scl_edges); end
  endtask

  task automatic test_two_entry();
    logic [31:0] f0;
    logic [31:0] f1;
    @(negedge clk_50M);
    mon_clear();
    sccb_sda_i = 1'b0;
    start_walk();
    n_cmp++; if (cfg_busy !== 1'b1) begin n_err++; $display("FAIL two_busy_t0: got %b expected 1", cfg_busy); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL two_addr_t0: got %0d expected 0", rom_addr); end
    step_to(7801);
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL two_addr_7801: got %0d expected 0", rom_addr); end
    step_to(7802);
    n_cmp++; if (rom_addr !== 10'd1) begin n_err++; $display("FAIL two_addr_7802: got %0d expected 1", rom_addr); end
    step_to(15603);
    n_cmp++; if ({cfg_done, cfg_busy} !== 2'b01) begin n_err++; $display("FAIL two_done_early: got %b expected 01", {cfg_done, cfg_busy}); end
    step_to(15604);
    n_cmp++; if ({cfg_done, cfg_busy} !== 2'b10) begin n_err++; $display("FAIL two_done_edge: got %b expected 10", {cfg_done, cfg_busy}); end
    n_cmp++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL two_nack: got %b expected 0", cfg_nack); end
    n_cmp++; if ({sccb_scl, sccb_sda_oe} !== 2'b10) begin n_err++; $display("FAIL two_bus_idle: got %b expected 10", {sccb_scl, sccb_sda_oe}); end
    f0 = (frames.size() > 0) ? frames[0] : 32'hxxxxxxxx;
    f1 = (frames.size() > 1) ? frames[1] : 32'hxxxxxxxx;
    n_cmp++; if (frames.size() !== 2) begin n_err++; $display("FAIL two_frame_count: got %0d expected 2", frames.size()); end
    n_cmp++; if (f0 !== 32'h78300882) begin n_err++; $display("FAIL two_frame0: got %h expected 78300882", f0); end
    n_cmp++; if (f1 !== 32'h78310303) begin n_err++; $display("FAIL two_frame1: got %h expected 78310303", f1); end
    n_cmp++; if (proto_err !== 0) begin n_err++; $display("FAIL two_protocol: got %0d errors expected 0", proto_err); end
    n_cmp++; if (period_err !== 0) begin n_err++; $display("FAIL scl_period: got %0d errors expected 0", period_err); end
    n_cmp++; if (high_err !== 0) begin n_err++; $display("FAIL scl_high: got %0d errors expected 0", high_err); end
    initial_en = 1'b0;
    @(posedge clk_50M);
    #1;
    n_cmp++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL done_abort: got %b expected 0", cfg_done); end
  endtask

  task automatic test_nack();
    @(negedge clk_50M);
    mon_clear();
    sccb_sda_i = 1'b0;
    start_walk();
    step_to(3602);
    sccb_sda_i = 1'b1;
    step_to(3751);
    n_cmp++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL nack_before_q3: got %b expected 0", cfg_nack); end
    step_to(3755);
    n_cmp++; if (cfg_nack !== 1'b1) begin n_err++; $display("FAIL nack_in_q3: got %b expected 1", cfg_nack); end
    step_to(3802);
    sccb_sda_i = 1'b0;
    step_to(15603);
    n_cmp++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL nack_done_early: got %b expected 0", cfg_done); end
    step_to(15604);
    n_cmp++; if ({cfg_done, cfg_nack} !== 2'b11) begin n_err++; $display("FAIL nack_done_edge: got %b expected 11", {cfg_done, cfg_nack}); end
    n_cmp++; if (frames.size() !== 2) begin n_err++; $display("FAIL nack_frame_count: got %0d expected 2", frames.size()); end
    initial_en = 1'b0;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic test_abort();
    @(negedge clk_50M);
    mon_clear();
    sccb_sda_i = 1'b1;
    start_walk();
    step_to(2000);
    n_cmp++; if (cfg_nack !== 1'b1) begin n_err++; $display("FAIL abort_nack_set: got %b expected 1", cfg_nack); end
    step_to(8414);
    n_cmp++; if ({sccb_scl, cfg_busy, rom_addr} !== {1'b0, 1'b1, 10'd1}) begin n_err++; $display("FAIL abort_pre: got scl=%b busy=%b addr=%0d expected 0 1 1", sccb_scl, cfg_busy, rom_addr); end
    initial_en = 1'b0;
    @(posedge clk_50M);
    #1;
    n_cmp++; if ({sccb_scl, sccb_sda_oe, cfg_busy, cfg_done} !== 4'b1000) begin n_err++; $display("FAIL abort_bus: got %b expected 1000", {sccb_scl, sccb_sda_oe, cfg_busy, cfg_done}); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL abort_addr: got %0d expected 0", rom_addr); end
    n_cmp++; if (cfg_nack !== 1'b1) begin n_err++; $display("FAIL abort_nack_held: got %b expected 1", cfg_nack); end
    sccb_sda_i = 1'b0;
    repeat (5) @(posedge clk_50M);
    #1;
    start_walk();
    n_cmp++; if ({cfg_busy, cfg_nack, rom_addr} !== {1'b1, 1'b0, 10'd0}) begin n_err++; $display("FAIL restart: got busy=%b nack=%b addr=%0d expected 1 0 0", cfg_busy, cfg_nack, rom_addr); end
    initial_en = 1'b0;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_50M);
    mon_clear();
    sccb_sda_i = 1'b1;
    start_walk();
    step_to(15502);
    n_cmp++; if ({cfg_nack, rom_addr} !== {1'b1, 10'd1}) begin n_err++; $display("FAIL rstmid_pre: got nack=%b addr=%0d expected 1 1", cfg_nack, rom_addr); end
    reset = 1'b1;
    @(posedge clk_50M);
    #1;
    n_cmp++; if ({sccb_scl, sccb_sda_oe, sccb_sda_o} !== 3'b100) begin n_err++; $display("FAIL rstmid_bus: got %b expected 100", {sccb_scl, sccb_sda_oe, sccb_sda_o}); end
    n_cmp++; if ({cfg_busy, cfg_done, cfg_nack} !== 3'b000) begin n_err++; $display("FAIL rstmid_status: got %b expected 000", {cfg_busy, cfg_done, cfg_nack}); end
    n_cmp++; if (rom_addr !== 10'd0) begin n_err++; $display("FAIL rstmid_addr: got %0d expected 0", rom_addr); end
    initial_en = 1'b0;
    sccb_sda_i = 1'b0;
    reset = 1'b0;
    @(posedge clk_50M);
    #1;
  endtask

  initial begin
    test_reset();
    test_two_entry();
    test_nack();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
